// File: rtl/plusarg_pkg.sv
// Shared types and ASCII constants for the run-time "+KEY=value" argument parser.
package plusarg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MATCH,
    EQ,
    VALUE,
    SKIP
  } state_e;

  localparam logic [7:0] PLUS   = 8'h2B;
  localparam logic [7:0] EQUALS = 8'h3D;
  localparam logic [7:0] SPACE  = 8'h20;
  localparam logic [7:0] LF     = 8'h0A;
  localparam logic [7:0] ZERO   = 8'h30;
  localparam logic [7:0] NINE   = 8'h39;

  function automatic logic is_sep(input logic [7:0] b);
    return (b == SPACE) || (b == LF);
  endfunction

endpackage

// File: rtl/plusarg_digit_decode.sv
// Byte to digit decoder: decimal always, hex letters a-f/A-F only while hex_i is high.
module plusarg_digit_decode
  import plusarg_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic       hex_i,
  output logic       is_digit_o,
  output logic [3:0] digit_o
);

  always_comb begin
    is_digit_o = 1'b0;
    digit_o    = 4'h0;
    if (byte_i >= ZERO && byte_i <= NINE) begin
      is_digit_o = 1'b1;
      digit_o    = byte_i[3:0];
    end else if (hex_i && ((byte_i >= 8'h61 && byte_i <= 8'h66) ||
                           (byte_i >= 8'h41 && byte_i <= 8'h46))) begin
      // 'a'/'A' have low nibble 1, so +9 maps them onto 10..15
      is_digit_o = 1'b1;
      digit_o    = byte_i[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/plusarg_parser.sv
// Streaming "+KEY=value" token parser with valid/ready output and malformed-value pulse.
// Define PLUSARG_HEX_EN to accept a leading "0x"/"0X" and hexadecimal digits in the value.
module plusarg_parser
  import plusarg_pkg::*;
#(
  parameter int                    W       = 8,
  parameter int                    KEY_LEN = 4,
  parameter logic [KEY_LEN*8-1:0]  KEY     = "SEED"
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_err
);

  localparam int AW = W + 4;
  localparam logic [AW-1:0] MAX_VAL = {4'h0, {W{1'b1}}};

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            have_dig_q, have_dig_d;
  logic            bad_q, bad_d;
  logic            ovf_q, ovf_d;
  logic            hex_q, hex_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_err_q, out_err_d;

  logic [7:0]      key_arr [16];
  logic            accept, sep, term, is_digit, hex_prefix;
  logic [3:0]      digit;
  logic [AW-1:0]   acc_mul, acc_step;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_key
      if (gi < KEY_LEN) begin : g_used
        assign key_arr[gi] = KEY[(KEY_LEN-1-gi)*8 +: 8];
      end else begin : g_pad
        assign key_arr[gi] = 8'h00;
      end
    end
  endgenerate

  plusarg_digit_decode u_decode (
    .byte_i    (in_data),
    .hex_i     (hex_q),
    .is_digit_o(is_digit),
    .digit_o   (digit)
  );

  assign in_ready = !(out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign sep      = is_sep(in_data);
  assign term     = sep || in_last;
  assign acc_mul  = hex_q ? {acc_q[AW-5:0], 4'h0} : ((acc_q << 3) + (acc_q << 1));
  assign acc_step = acc_mul + {{W{1'b0}}, digit};

`ifdef PLUSARG_HEX_EN
  logic [1:0] nchar_q, nchar_d;
  // "0x" is only a prefix when the '0' was the single character seen so far
  assign hex_prefix = (nchar_q == 2'd1) && have_dig_q && (acc_q == '0) && !hex_q &&
                      ((in_data == 8'h78) || (in_data == 8'h58));
`else
  assign hex_prefix = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    have_dig_d  = have_dig_q;
    bad_d       = bad_q;
    ovf_d       = ovf_q;
    hex_d       = hex_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    out_err_d   = 1'b0;
`ifdef PLUSARG_HEX_EN
    nchar_d     = nchar_q;
`endif
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (term)                  state_d = IDLE;
          else if (in_data == PLUS) begin
            state_d = MATCH;
            idx_d   = 4'd0;
          end else                   state_d = SKIP;
        end
        MATCH: begin
          if (term) state_d = IDLE;
          else if (in_data == key_arr[idx_q]) begin
            if (idx_q == 4'(KEY_LEN - 1)) state_d = EQ;
            else                          idx_d   = idx_q + 4'd1;
          end else state_d = SKIP;
        end
        EQ: begin
          if (term) state_d = IDLE;
          else if (in_data == EQUALS) begin
            state_d    = VALUE;
            acc_d      = '0;
            have_dig_d = 1'b0;
            bad_d      = 1'b0;
            ovf_d      = 1'b0;
            hex_d      = 1'b0;
`ifdef PLUSARG_HEX_EN
            nchar_d    = 2'd0;
`endif
          end else state_d = SKIP;
        end
        VALUE: begin
          if (!sep) begin
`ifdef PLUSARG_HEX_EN
            if (nchar_q != 2'd2) nchar_d = nchar_q + 2'd1;
`endif
            if (hex_prefix) begin
              hex_d      = 1'b1;
              have_dig_d = 1'b0;
            end else if (is_digit) begin
              acc_d      = acc_step;
              have_dig_d = 1'b1;
              if (acc_step > MAX_VAL) ovf_d = 1'b1;
            end else begin
              bad_d = 1'b1;
            end
          end
          if (term) begin
            if (have_dig_d && !bad_d && !ovf_d) begin
              out_data_d  = acc_d[W-1:0];
              out_valid_d = 1'b1;
            end else begin
              out_err_d = 1'b1;
            end
            state_d = IDLE;
          end
        end
        SKIP: begin
          if (term) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      acc_q       <= '0;
      have_dig_q  <= 1'b0;
      bad_q       <= 1'b0;
      ovf_q       <= 1'b0;
      hex_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      have_dig_q  <= have_dig_d;
      bad_q       <= bad_d;
      ovf_q       <= ovf_d;
      hex_q       <= hex_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

`ifdef PLUSARG_HEX_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) nchar_q <= 2'd0;
    else       nchar_q <= nchar_d;
  end
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_plusarg_parser.sv
// Scoreboard bench for plusarg_parser: driver queues expected events, a monitor pops and checks them.
module tb_plusarg_parser;

  localparam int K_NONE = 0;
  localparam int K_VAL  = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } evt_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  evt_t       exp_evt[$];
  logic [7:0] exp_hs[$];

  plusarg_parser #(.W(8), .KEY_LEN(4), .KEY("SEED")) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input int kind, input logic [7:0] data);
    int   n;
    bit   done;
    evt_t e;
    in_data  = b;
    in_valid = 1'b1;
    in_last  = last;
    done     = 1'b0;
    n        = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        if (kind != K_NONE) begin
          e.kind = kind;
          e.data = data;
          e.cyc  = cyc + 1;
          exp_evt.push_back(e);
        end
        if (kind == K_VAL) exp_hs.push_back(data);
        done = 1'b1;
      end else begin
        n++;
        if (n > 50) begin
          checks++;
          errors++;
          $display("FAIL in_ready_timeout: byte 0x%02h not accepted within 50 cycles", b);
          done = 1'b1;
        end
      end
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Expected outcome is attached to the final byte of the string.
  task automatic send_str(input string s, input bit last, input int kind, input logic [7:0] data);
    for (int i = 0; i < s.len(); i++) begin
      if (i == s.len() - 1) send_byte(s[i], last, kind, data);
      else                  send_byte(s[i], 1'b0, K_NONE, 8'h00);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: new output events (valid rise or error pulse) and handshakes.
  initial begin : monitor
    bit   prev_valid;
    bit   prev_hs;
    bit   new_val;
    int   kind_act;
    evt_t e;
    logic [7:0] d;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
      end else begin
        new_val = out_valid && (!prev_valid || prev_hs);
        if (out_err || new_val) begin
          checks++;
          kind_act = out_err ? K_ERR : K_VAL;
          if (exp_evt.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: kind=%0d data=0x%02h at cycle %0d, expected none", kind_act, out_data, cyc);
          end else begin
            e = exp_evt.pop_front();
            if (kind_act != e.kind || cyc != e.cyc || (kind_act == K_VAL && out_data != e.data)) begin
              errors++;
              $display("FAIL event: got kind=%0d data=0x%02h cycle=%0d, expected kind=%0d data=0x%02h cycle=%0d",
                       kind_act, out_data, cyc, e.kind, e.data, e.cyc);
            end else begin
              $display("ok   event: kind=%0d data=0x%02h cycle=%0d", kind_act, out_data, cyc);
            end
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_hs.size() == 0) begin
            errors++;
            $display("FAIL unexpected_handshake: data=0x%02h, expected none", out_data);
          end else begin
            d = exp_hs.pop_front();
            if (out_data != d) begin
              errors++;
              $display("FAIL handshake: got 0x%02h, expected 0x%02h", out_data, d);
            end else begin
              $display("ok   handshake: data=0x%02h", out_data);
            end
          end
        end
        prev_valid = out_valid;
        prev_hs    = out_valid && out_ready;
      end
    end
  end

  initial begin : stim
    int n;
    int lowc;
    bit seen;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_err",   int'(out_err),   0);
    check("reset_out_data",  int'(out_data),  0);
    check("reset_in_ready",  int'(in_ready),  1);
    @(posedge clk);
    #1;

    // Overflow: 300 does not fit in 8 bits
    send_str("+SEED=300\n", 1'b0, K_ERR, 8'h00);
    idle(3);
    check("ovf_out_data_kept", int'(out_data), 0);
    check("ovf_out_valid_low", int'(out_valid), 0);

    send_str("+SEED=42\n", 1'b0, K_VAL, 8'h2A);
    idle(2);
    send_str("+SEED=255\n", 1'b0, K_VAL, 8'hFF);
    idle(2);
    send_str("+SEED=\n", 1'b0, K_ERR, 8'h00);
    send_str("+SEED=4a\n", 1'b0, K_ERR, 8'h00);
    idle(2);
    check("err_out_data_kept", int'(out_data), 255);

    // Non-matching keys skipped; in_last on the final digit terminates
    send_str("+SEEDX=5 +SED=6 +SEEX=8 +SEED=7", 1'b1, K_VAL, 8'h07);
    idle(2);
    // in_last mid-key: no output, next stream starts clean
    send_str("+SEE", 1'b1, K_NONE, 8'h00);
    send_str("+SEED=1 ", 1'b0, K_VAL, 8'h01);
    idle(2);

    // Output stall holds the byte stream
    out_ready = 1'b0;
    fork
      begin
        send_str("+SEED=9\n", 1'b0, K_VAL, 8'h09);
        send_str("+SEED=3\n", 1'b0, K_VAL, 8'h03);
      end
      begin
        n    = 0;
        lowc = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
          @(negedge clk);
          n++;
          if (out_valid) seen = 1'b1;
        end
        if (seen) begin
          if (!in_ready) lowc++;
          repeat (2) begin
            @(negedge clk);
            if (!in_ready) lowc++;
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        check("stall_in_ready_low_cycles", lowc, 3);
      end
    join
    idle(3);
    check("last_wins_out_data", int'(out_data), 3);

`ifdef PLUSARG_HEX_EN
    send_str("+SEED=0xFF\n", 1'b0, K_VAL, 8'hFF);
`else
    send_str("+SEED=0xFF\n", 1'b0, K_ERR, 8'h00);
`endif
    idle(3);

    // Reset mid-token discards the partial parse
    send_str("+SE", 1'b0, K_NONE, 8'h00);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    send_str("ED=1\n", 1'b0, K_NONE, 8'h00);
    idle(3);
    check("post_reset_out_data", int'(out_data), 0);

    idle(5);
    check("pending_events", exp_evt.size(), 0);
    check("pending_handshakes", exp_hs.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
